led_pattern_sequencer: RTL

//  Autonomous controller for the 4-bit LED PIO. Nios software loads a short

---
 rtl/led_seq_pkg.sv | 24 ++
 rtl/led_step_timer.sv | 27 ++
 rtl/led_pattern_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// Shared state encoding, register map and bit positions for the LED pattern sequencer.
// No logic; imported by the top and the bench.
package led_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic [2:0] ADDR_CTRL   = 3'd0;
   localparam logic [2:0] ADDR_PERIOD = 3'd1;
   localparam logic [2:0] ADDR_STATUS = 3'd2;
   localparam logic [2:0] ADDR_RSVD   = 3'd3;

   localparam int CTRL_RUN     = 0;
   localparam int CTRL_LOOP    = 1;
   localparam int CTRL_LAST_LO = 8;

   localparam int STAT_IDX_LO = 0;
   localparam int STAT_BUSY   = 8;
   localparam int STAT_DONE   = 9;

endpackage

// File: rtl/led_step_timer.sv
// Step-period down-counter: load wins, otherwise decrements to zero and holds there.
// zero is combinational from the count, so a load of 0 expires on the following cycle.
module led_step_timer #(
   parameter int CNT_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/led_pattern_sequencer.sv
// Replays a 4-entry LED pattern table as Avalon-MM writes to PIO register 0, once or looped.
// First write is issued the cycle after run is written; a stalled write is held until waitrequest drops.
module led_pattern_sequencer
   import led_seq_pkg::*;
#(
   parameter int LED_W = 4,
   parameter int DEPTH = 4,
   parameter int CNT_W = 24
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  s_address,
   input  logic        s_chipselect,
   input  logic        s_write_n,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   output logic [1:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [31:0] m_writedata,
   input  logic        m_waitrequest,
   output logic        busy
);

   logic             wr_en;
   logic             ctrl_wr;
   logic             status_wr;
   logic             run;
   logic             run_eff;
   logic             loop;
   logic [1:0]       last;
   logic [CNT_W-1:0] period;
   logic [LED_W-1:0] pat [DEPTH];
   state_t           state;
   logic [1:0]       idx;
   logic [1:0]       idx_inc;
   logic             done;
   logic             tmr_load;
   logic             tmr_zero;
   logic [CNT_W-1:0] tmr_val;
   logic             unused_wdata;

   assign wr_en     = s_chipselect && !s_write_n;
   assign ctrl_wr   = wr_en && (s_address == ADDR_CTRL);
   assign status_wr = wr_en && (s_address == ADDR_STATUS);

   // A CTRL write acts in the same cycle it is accepted, so start and stop are not delayed a cycle.
   assign run_eff = ctrl_wr ? s_writedata[CTRL_RUN] : run;

   assign idx_inc   = idx + 2'd1;
   assign m_address = 2'b00;
   assign busy      = (state != IDLE);

   assign unused_wdata = &{1'b0, s_writedata};

   // Configuration registers; run and done live with the FSM since it also modifies them.
   always_ff @(posedge clk) begin
      if (reset) begin
         loop   <= 1'b0;
         last   <= 2'd0;
         period <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pat[i] <= '0;
         end
      end else if (wr_en) begin
         case (s_address)
            ADDR_CTRL: begin
               loop <= s_writedata[CTRL_LOOP];
               last <= s_writedata[CTRL_LAST_LO +: 2];
            end
            ADDR_PERIOD: period <= s_writedata[CNT_W-1:0];
            ADDR_STATUS, ADDR_RSVD: ;
            default: pat[s_address[1:0]] <= s_writedata[LED_W-1:0];
         endcase
      end
   end

   // A zero period behaves as one, so the gap always lasts at least one cycle.
   assign tmr_load = (state == WRITE) && !m_waitrequest;
   assign tmr_val  = (period == '0) ? '0 : period - 1'b1;

   led_step_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         idx          <= 2'd0;
         run          <= 1'b0;
         done         <= 1'b0;
         m_chipselect <= 1'b0;
         m_write_n    <= 1'b1;
         m_writedata  <= '0;
      end else begin
         if (ctrl_wr) begin
            run <= s_writedata[CTRL_RUN];
         end
         if (status_wr || (ctrl_wr && s_writedata[CTRL_RUN])) begin
            done <= 1'b0;
         end

         // Any done/run update below is later in the block, so completion beats a software clear.
         case (state)
            IDLE: begin
               if (run_eff) begin
                  idx          <= 2'd0;
                  state        <= WRITE;
                  m_chipselect <= 1'b1;
                  m_write_n    <= 1'b0;
                  m_writedata  <= {{(32-LED_W){1'b0}}, pat[0]};
               end
            end
            WRITE: begin
               if (!m_waitrequest) begin
                  m_chipselect <= 1'b0;
                  m_write_n    <= 1'b1;
                  state        <= run_eff ? GAP : IDLE;
               end
            end
            GAP: begin
               if (!run_eff) begin
                  state <= IDLE;
               end else if (tmr_zero) begin
                  if (idx < last) begin
                     idx          <= idx_inc;
                     state        <= WRITE;
                     m_chipselect <= 1'b1;
                     m_write_n    <= 1'b0;
                     m_writedata  <= {{(32-LED_W){1'b0}}, pat[idx_inc]};
                  end else if (loop) begin
                     idx          <= 2'd0;
                     state        <= WRITE;
                     m_chipselect <= 1'b1;
                     m_write_n    <= 1'b0;
                     m_writedata  <= {{(32-LED_W){1'b0}}, pat[0]};
                  end else begin
                     done  <= 1'b1;
                     run   <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      s_readdata = '0;
      case (s_address)
         ADDR_CTRL: begin
            s_readdata[CTRL_RUN]           = run;
            s_readdata[CTRL_LOOP]          = loop;
            s_readdata[CTRL_LAST_LO +: 2]  = last;
         end
         ADDR_PERIOD: s_readdata[CNT_W-1:0] = period;
         ADDR_STATUS: begin
            s_readdata[STAT_IDX_LO +: 2] = idx;
            s_readdata[STAT_BUSY]        = busy;
            s_readdata[STAT_DONE]        = done;
         end
         ADDR_RSVD: s_readdata = '0;
         default: s_readdata[LED_W-1:0] = pat[s_address[1:0]];
      endcase
   end

endmodule
